// File: rtl/vga_rx_capture.sv
// VGA stream sink: rebuilds pixel coordinates from the RGB/sync/valid stream,
// writes active pixels to a frame-buffer port and reports per-frame checksum,
// line/frame geometry status and a completed-frame count.
module vga_rx_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int XW              = 10,
  parameter int YW              = 10,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  input  logic          vga_hsync,
  input  logic          vga_vsync,
  input  logic          vga_valid,
  output logic          pix_we,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [23:0]   pix_data,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [31:0]   frame_sum,
  output logic [15:0]   frame_cnt,
  output logic          locked
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    VSYNC = 2'd1,
    FRAME = 2'd2
  } state_t;

  localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

  // Polarity-corrected syncs straight from the pins
  logic hs_act_in;
  logic vs_act_in;
  assign hs_act_in = SYNC_ACTIVE_LOW ? ~vga_hsync : vga_hsync;
  assign vs_act_in = SYNC_ACTIVE_LOW ? ~vga_vsync : vga_vsync;

  // Stage S1 registers plus the previous S1 sync levels for edge detection
  logic [23:0] rgb_s1;
  logic        valid_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic        hs_prev;
  logic        vs_prev;

  // Capture the incoming stream once; everything downstream works on S1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rgb_s1   <= '0;
      valid_s1 <= 1'b0;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      rgb_s1   <= {vga_r, vga_g, vga_b};
      valid_s1 <= vga_valid;
      hs_s1    <= hs_act_in;
      vs_s1    <= vs_act_in;
      hs_prev  <= hs_s1;
      vs_prev  <= vs_s1;
    end
  end

  // A held sync level yields a single assertion edge
  logic hs_edge;
  logic vs_edge;
  assign hs_edge = hs_s1 & ~hs_prev;
  assign vs_edge = vs_s1 & ~vs_prev;

  state_t        state_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [31:0]   sum_reg;
  logic          line_err_reg;
  logic          frame_err_reg;

  // Per-cycle step in FRAME: pixel first, then line close, then frame close
  logic          in_x;
  logic          in_y;
  logic          wr_ok;
  logic [XW-1:0] x_pix;
  logic [31:0]   sum_pix;
  logic          lerr_pix;
  logic          ferr_pix;
  logic          close_line;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic          lerr_next;
  logic          ferr_frame;

  // Same-cycle pixel and sync edge: the pixel belongs to the closing line
  always_comb begin
    in_x       = (x_reg < H_LIM);
    in_y       = (y_reg < V_LIM);
    wr_ok      = valid_s1 & in_x & in_y;
    x_pix      = wr_ok ? (x_reg + 1'b1) : x_reg;
    sum_pix    = wr_ok ? ({sum_reg[30:0], sum_reg[31]} ^ {8'h00, rgb_s1}) : sum_reg;
    lerr_pix   = line_err_reg | (valid_s1 & ~in_x);
    ferr_pix   = frame_err_reg | (valid_s1 & ~in_y);
    // Empty blanking lines (x still 0) do not advance the row
    close_line = (hs_edge | vs_edge) & (x_pix != '0);
    x_next     = close_line ? '0 : x_pix;
    y_next     = y_reg;
    if (close_line && (y_reg != '1)) begin
      y_next = y_reg + 1'b1;
    end
    lerr_next  = lerr_pix | (close_line & (x_pix != H_LIM));
    ferr_frame = ferr_pix | (y_next != V_LIM);
  end

  // Capture FSM with registered frame-buffer and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= HUNT;
      x_reg         <= '0;
      y_reg         <= '0;
      sum_reg       <= '0;
      line_err_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      pix_we        <= 1'b0;
      pix_x         <= '0;
      pix_y         <= '0;
      pix_data      <= '0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_sum     <= '0;
      frame_cnt     <= '0;
      locked        <= 1'b0;
    end else begin
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (vs_edge) begin
            state_reg <= VSYNC;
            locked    <= 1'b1;
          end
        end
        VSYNC: begin
          x_reg         <= '0;
          y_reg         <= '0;
          sum_reg       <= '0;
          line_err_reg  <= 1'b0;
          frame_err_reg <= 1'b0;
          if (!vs_s1) begin
            state_reg <= FRAME;
          end
        end
        FRAME: begin
          pix_we <= wr_ok;
          if (wr_ok) begin
            pix_x    <= x_reg;
            pix_y    <= y_reg;
            pix_data <= rgb_s1;
          end
          x_reg         <= x_next;
          y_reg         <= y_next;
          sum_reg       <= sum_pix;
          line_err_reg  <= lerr_next;
          frame_err_reg <= ferr_pix;
          if (vs_edge) begin
            frame_done <= 1'b1;
            frame_ok   <= ~(lerr_next | ferr_frame);
            frame_sum  <= sum_pix;
            frame_cnt  <= frame_cnt + 16'd1;
            state_reg  <= VSYNC;
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Bench for vga_rx_capture with a 4x3 frame: table of frames plus scoreboard
// queues for pixel writes and frame results, and hand-written reset/lock cases.
module tb_vga_rx_capture;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int XW = 3;
  localparam int YW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    vga_r = '0;
  logic [7:0]    vga_g = '0;
  logic [7:0]    vga_b = '0;
  logic          vga_hsync = 1'b1;
  logic          vga_vsync = 1'b1;
  logic          vga_valid = 1'b0;
  logic          pix_we;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [23:0]   pix_data;
  logic          frame_done;
  logic          frame_ok;
  logic [31:0]   frame_sum;
  logic [15:0]   frame_cnt;
  logic          locked;

  vga_rx_capture #(
    .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_sum(frame_sum),
    .frame_cnt(frame_cnt), .locked(locked)
  );

  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [23:0]   d;
    int            cyc;
  } pix_exp_t;

  typedef struct {
    logic        ok;
    logic [31:0] sum;
    logic [15:0] cnt;
    int          cyc;
  } frm_exp_t;

  typedef struct {
    int nlines;
    int len [4];
    bit inc_rgb;
    bit same;
    bit exp_ok;
  } frame_vec_t;

  pix_exp_t    exp_pix [$];
  frm_exp_t    exp_frm [$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_sum  = '0;
  int          exp_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Scoreboard: compare DUT outputs against the queued expectations
  always @(negedge clock) begin
    if (pix_we) begin
      if (exp_pix.size() == 0) begin
        chk("unexpected_write", 32'(pix_we), 32'd0);
      end else begin
        pix_exp_t e;
        e = exp_pix.pop_front();
        chk("pix_x", 32'(pix_x), 32'(e.x));
        chk("pix_y", 32'(pix_y), 32'(e.y));
        chk("pix_data", 32'(pix_data), 32'(e.d));
        chk("pix_cycle", 32'(cyc_cnt), 32'(e.cyc));
        $display("write x=%0d y=%0d data=%h cycle=%0d", pix_x, pix_y, pix_data, cyc_cnt);
      end
    end else if (exp_pix.size() != 0 && exp_pix[0].cyc <= cyc_cnt) begin
      void'(exp_pix.pop_front());
      chk("missing_write", 32'(pix_we), 32'd1);
    end
    if (frame_done) begin
      if (exp_frm.size() == 0) begin
        chk("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        frm_exp_t f;
        f = exp_frm.pop_front();
        chk("frame_ok", 32'(frame_ok), 32'(f.ok));
        chk("frame_sum", frame_sum, f.sum);
        chk("frame_cnt", 32'(frame_cnt), 32'(f.cnt));
        chk("frame_cycle", 32'(cyc_cnt), 32'(f.cyc));
        $display("frame ok=%0b sum=%h cnt=%0d cycle=%0d", frame_ok, frame_sum, frame_cnt, cyc_cnt);
      end
    end else if (exp_frm.size() != 0 && exp_frm[0].cyc <= cyc_cnt) begin
      void'(exp_frm.pop_front());
      chk("missing_frame_done", 32'(frame_done), 32'd1);
    end
  end

  // One stream cycle; n is the cycle number the sample edge closes
  task automatic drive(input bit hs_low, input bit vs_low, input bit v,
                       input logic [23:0] rgb, output int n);
    vga_hsync = ~hs_low;
    vga_vsync = ~vs_low;
    vga_valid = v;
    {vga_r, vga_g, vga_b} = rgb;
    n = cyc_cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame(input bit ok, input int n);
    frm_exp_t f;
    exp_frames++;
    f.ok  = ok;
    f.sum = exp_sum;
    f.cnt = 16'(exp_frames);
    f.cyc = n + 2;
    exp_frm.push_back(f);
    exp_sum = '0;
  endtask

  task automatic vs_start();
    int n;
    drive(0, 1, 0, 24'h0, n);
    drive(0, 1, 0, 24'h0, n);
    drive(0, 0, 0, 24'h0, n);
    drive(0, 0, 0, 24'h0, n);
  endtask

  // Lines of valid pixels, each closed by an hsync pulse, then the vsync pulse
  task automatic run_frame(input frame_vec_t fv);
    int n;
    bit last;
    logic [23:0] rgb;
    pix_exp_t p;
    exp_sum = '0;
    for (int l = 0; l < fv.nlines; l++) begin
      for (int k = 0; k < fv.len[l]; k++) begin
        rgb  = fv.inc_rgb ? {8'(l + 1), 8'(k * 17), 8'hA5} : 24'h000001;
        last = fv.same && (l == fv.nlines - 1) && (k == fv.len[l] - 1);
        drive(last, last, 1, rgb, n);
        if (k < H && l < V) begin
          p.x = XW'(k);
          p.y = YW'(l);
          p.d = rgb;
          p.cyc = n + 2;
          exp_pix.push_back(p);
          exp_sum = {exp_sum[30:0], exp_sum[31]} ^ {8'h00, rgb};
        end
        if (last) push_frame(fv.exp_ok, n);
      end
      if (!(fv.same && l == fv.nlines - 1)) drive(1, 0, 0, 24'h0, n);
    end
    if (fv.same) begin
      drive(0, 1, 0, 24'h0, n);
    end else begin
      drive(0, 1, 0, 24'h0, n);
      push_frame(fv.exp_ok, n);
      drive(0, 1, 0, 24'h0, n);
    end
    drive(0, 0, 0, 24'h0, n);
    drive(0, 0, 0, 24'h0, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_we"},     32'(pix_we), 32'd0);
    chk({tag, "_pix_x"},      32'(pix_x), 32'd0);
    chk({tag, "_pix_y"},      32'(pix_y), 32'd0);
    chk({tag, "_pix_data"},   32'(pix_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_ok"},   32'(frame_ok), 32'd0);
    chk({tag, "_frame_sum"},  frame_sum, 32'd0);
    chk({tag, "_frame_cnt"},  32'(frame_cnt), 32'd0);
    chk({tag, "_locked"},     32'(locked), 32'd0);
  endtask

  frame_vec_t tbl [8];

  initial begin
    int n;
    frame_vec_t good;
    tbl[0] = '{nlines: 3, len: '{4, 4, 4, 0}, inc_rgb: 0, same: 0, exp_ok: 1};
    tbl[1] = '{nlines: 3, len: '{4, 5, 4, 0}, inc_rgb: 0, same: 0, exp_ok: 0};
    tbl[2] = '{nlines: 3, len: '{4, 4, 4, 0}, inc_rgb: 0, same: 0, exp_ok: 1};
    tbl[3] = '{nlines: 2, len: '{4, 4, 0, 0}, inc_rgb: 0, same: 0, exp_ok: 0};
    tbl[4] = '{nlines: 3, len: '{4, 4, 4, 0}, inc_rgb: 1, same: 0, exp_ok: 1};
    tbl[5] = '{nlines: 3, len: '{4, 4, 4, 0}, inc_rgb: 0, same: 1, exp_ok: 1};
    tbl[6] = '{nlines: 3, len: '{4, 3, 4, 0}, inc_rgb: 1, same: 0, exp_ok: 0};
    tbl[7] = '{nlines: 4, len: '{4, 4, 4, 2}, inc_rgb: 0, same: 0, exp_ok: 0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // Valid pixels before any vsync are ignored and do not lock
    drive(0, 0, 1, 24'h123456, n);
    drive(0, 0, 1, 24'h123457, n);
    drive(0, 0, 1, 24'h123458, n);
    drive(0, 0, 0, 24'h0, n);
    chk("locked_before_vsync", 32'(locked), 32'd0);
    vs_start();
    chk("locked_after_vsync", 32'(locked), 32'd1);

    // Table of frames
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i]);
    end
    repeat (3) drive(0, 0, 0, 24'h0, n);
    chk("frame_cnt_after_table", 32'(frame_cnt), 32'd8);

    // Reset pulsed mid-line: outputs clear at once, capture restarts cleanly
    drive(0, 0, 1, 24'h0000AA, n);
    drive(0, 0, 1, 24'h0000BB, n);
    reset = 1'b0;
    exp_pix.delete();
    exp_frm.delete();
    exp_frames = 0;
    #1;
    chk_all_zero("midreset");
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    vs_start();
    good = tbl[0];
    run_frame(good);
    repeat (4) drive(0, 0, 0, 24'h0, n);
    chk("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);
    chk("frame_ok_held", 32'(frame_ok), 32'd1);
    chk("frame_sum_held", frame_sum, 32'h00000FFF);
    chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    chk("frame_queue_drained", 32'(exp_frm.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
